alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready handshake on both sides.
// Shifts take one cycle per bit position; every other op completes in one cycle.
// Build option: define ALU_SEQ_FLAGS_EN to get the {N,Z,C,V} flag logic;
// without it, flags is tied to zero and no flag hardware is built.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] param1,
  input  logic [WIDTH-1:0] param2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_PASSB = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NAND  = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_INC   = 4'd10;
  localparam logic [3:0] OP_DEC   = 4'd11;
  localparam logic [3:0] OP_CMP   = 4'd12;
  localparam logic [3:0] OP_ZERO  = 4'd13;
  localparam logic [3:0] OP_NOP0  = 4'd14;
  localparam logic [3:0] OP_NOP1  = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] sh_q, sh_nxt;
  logic             left_q;
  logic [WIDTH-1:0] alu_res;
  logic             accept, is_shift, amt_nz, last_step;

  assign in_ready  = (state_q == S_IDLE) && rst_n_in;
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign is_shift  = (op == OP_SHL) || (op == OP_SHR);
  assign amt_nz    = |param2[SHW-1:0];
  assign last_step = (state_q == S_SHIFT) && (cnt_q == SHW'(1));
  assign result    = result_q;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic: the DONE state refuses new work, so at most one op per two cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (is_shift && amt_nz) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_q == SHW'(1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle result; shifts with a zero amount, cmp and nop all return A.
  always_comb begin
    alu_res = param1;
    case (op)
      OP_PASSB: alu_res = param2;
      OP_ADD:   alu_res = param1 + param2;
      OP_SUB:   alu_res = param1 - param2;
      OP_AND:   alu_res = param1 & param2;
      OP_OR:    alu_res = param1 | param2;
      OP_XOR:   alu_res = param1 ^ param2;
      OP_NAND:  alu_res = ~(param1 & param2);
      OP_INC:   alu_res = param1 + WIDTH'(1);
      OP_DEC:   alu_res = param1 - WIDTH'(1);
      OP_ZERO:  alu_res = '0;
      default:  alu_res = param1;
    endcase
  end

  // One bit position per SHIFT cycle in the captured direction.
  always_comb begin
    if (left_q) sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
    else        sh_nxt = {1'b0, sh_q[WIDTH-1:1]};
  end

  // Shift operand and direction are captured on accept so later input changes are ignored.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      sh_q   <= param1;
      left_q <= (op == OP_SHL);
    end else if (state_q == S_SHIFT) begin
      sh_q   <= sh_nxt;
    end
  end

  // Result and shift counter; the final shift step writes the result as it enters DONE.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      result_q <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      if (is_shift && amt_nz) cnt_q <= param2[SHW-1:0];
      else                    result_q <= alu_res;
    end else if (state_q == S_SHIFT) begin
      cnt_q <= cnt_q - SHW'(1);
      if (last_step) result_q <= sh_nxt;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0]       flags_q, alu_flags;
  logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w;
  logic [WIDTH-1:0] fsrc;
  logic             fc, fv, keep, sh_out;

  function automatic logic ovf_add(input logic [WIDTH-1:0] a, b, s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic ovf_sub(input logic [WIDTH-1:0] a, b, d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign add_w  = {1'b0, param1} + {1'b0, param2};
  assign sub_w  = {1'b0, param1} - {1'b0, param2};
  assign inc_w  = {1'b0, param1} + (WIDTH+1)'(1);
  assign dec_w  = {1'b0, param1} - (WIDTH+1)'(1);
  assign sh_out = left_q ? sh_q[WIDTH-1] : sh_q[0];
  assign flags  = flags_q;

  // Flags for single-cycle ops; the top bit of the extended sum/difference is carry/borrow.
  always_comb begin
    fsrc = alu_res;
    fc   = 1'b0;
    fv   = 1'b0;
    keep = 1'b0;
    case (op)
      OP_ADD: begin fc = add_w[WIDTH]; fv = ovf_add(param1, param2, add_w[WIDTH-1:0]); end
      OP_SUB: begin fc = sub_w[WIDTH]; fv = ovf_sub(param1, param2, sub_w[WIDTH-1:0]); end
      OP_INC: begin fc = inc_w[WIDTH]; fv = ovf_add(param1, WIDTH'(1), inc_w[WIDTH-1:0]); end
      OP_DEC: begin fc = dec_w[WIDTH]; fv = ovf_sub(param1, WIDTH'(1), dec_w[WIDTH-1:0]); end
      OP_CMP: begin
        fsrc = sub_w[WIDTH-1:0];
        fc   = sub_w[WIDTH];
        fv   = ovf_sub(param1, param2, sub_w[WIDTH-1:0]);
      end
      OP_NOP0, OP_NOP1: keep = 1'b1;
      default: ;
    endcase
    alu_flags = {fsrc[WIDTH-1], (fsrc == '0), fc, fv};
  end

  // Flags register, written alongside the result; nop leaves it untouched.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      flags_q <= '0;
    end else if (accept) begin
      if (!(is_shift && amt_nz) && !keep) flags_q <= alu_flags;
    end else if (last_step) begin
      flags_q <= {sh_nxt[WIDTH-1], (sh_nxt == '0), sh_out, 1'b0};
    end
  end
`else
  assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8). Expected flags follow ALU_SEQ_FLAGS_EN.
module tb_alu_seq;

  localparam int W = 8;

  typedef struct {
    logic [7:0] res;
    logic [3:0] fl;
    int         lat;
  } exp_t;

  logic       clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic       in_ready, out_valid;
  logic [3:0] op = 4'd0, flags;
  logic [7:0] p1 = 8'h00, p2 = 8'h00, result;

  exp_t       sb[$];
  logic [3:0] mflags = 4'h0;
  int         checks = 0, passed = 0;

  logic [19:0] tbl [0:20] = '{
    {4'd2, 8'h03, 8'h02}, {4'd3, 8'h02, 8'h03}, {4'd2, 8'h7F, 8'h01}, {4'd8, 8'h81, 8'h03},
    {4'd9, 8'h81, 8'h01}, {4'd2, 8'hFF, 8'h01}, {4'd12, 8'h05, 8'h07}, {4'd14, 8'h33, 8'h00},
    {4'd10, 8'hFF, 8'h00}, {4'd11, 8'h00, 8'h00}, {4'd11, 8'h80, 8'h00}, {4'd8, 8'h80, 8'h08},
    {4'd13, 8'h5A, 8'hA5}, {4'd7, 8'hF0, 8'hFF}, {4'd1, 8'h12, 8'h34}, {4'd3, 8'h80, 8'h01},
    {4'd6, 8'hC3, 8'h3C}, {4'd15, 8'h44, 8'h00}, {4'd0, 8'h9C, 8'h11}, {4'd4, 8'hF0, 8'h3C},
    {4'd5, 8'h0F, 8'h30}
  };

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .param1(p1), .param2(p2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  function automatic logic ovf(input int s);
    return (s > 127) || (s < -128);
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] pf);
    exp_t e;
    int ua, ub, sa, sbv, t, amt;
    logic [7:0] r, fr;
    logic c, v, keep, cmp;
    ua = int'(a); ub = int'(b); sa = int'($signed(a)); sbv = int'($signed(b));
    amt = int'(b[2:0]);
    r = a; c = 1'b0; v = 1'b0; keep = 1'b0; cmp = 1'b0; t = 0;
    case (o)
      4'd1:  r = b;
      4'd2:  begin t = ua + ub; r = t[7:0]; c = (t > 255); v = ovf(sa + sbv); end
      4'd3:  begin t = ua - ub; r = t[7:0]; c = (ua < ub); v = ovf(sa - sbv); end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~(a & b);
      4'd8:  for (int i = 0; i < amt; i++) begin c = r[7]; r = {r[6:0], 1'b0}; end
      4'd9:  for (int i = 0; i < amt; i++) begin c = r[0]; r = {1'b0, r[7:1]}; end
      4'd10: begin t = ua + 1; r = t[7:0]; c = (t > 255); v = ovf(sa + 1); end
      4'd11: begin t = ua - 1; r = t[7:0]; c = (ua == 0); v = ovf(sa - 1); end
      4'd12: begin t = ua - ub; cmp = 1'b1; c = (ua < ub); v = ovf(sa - sbv); end
      4'd13: r = 8'h00;
      4'd14, 4'd15: keep = 1'b1;
      default: r = a;
    endcase
    fr = cmp ? t[7:0] : r;
`ifdef ALU_SEQ_FLAGS_EN
    e.fl = keep ? pf : {fr[7], (fr == 8'h00), c, v};
`else
    e.fl = 4'h0;
`endif
    e.res = r;
    e.lat = ((o == 4'd8 || o == 4'd9) && amt != 0) ? amt + 1 : 1;
    return e;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    if (sb.size() == 0) begin
      e.res = 8'hxx; e.fl = 4'hx; e.lat = -1;
    end else begin
      e = sb.pop_front();
    end
    return e;
  endfunction

  task automatic send(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (in_ready !== 1'b1) $display("FAIL send_ready in_ready=%b want 1", in_ready);
    else passed++;
    checks++;
    in_valid = 1'b1; op = o; p1 = a; p2 = b;
    e = model(o, a, b, mflags);
    mflags = e.fl;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); p1 = 8'($urandom); p2 = 8'($urandom);
  endtask

  task automatic collect(output logic [7:0] r, output logic [3:0] f, output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    r = result;
    f = flags;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else passed++;
    checks++;
    repeat (2) @(posedge clk);
    #1;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else passed++;
    checks++;
    if (result !== 8'h00) $display("FAIL rst_result got %h want 00", result); else passed++;
    checks++;
    if (flags !== 4'h0) $display("FAIL rst_flags got %h want 0", flags); else passed++;
    checks++;
    rst_n = 1'b1;
    mflags = 4'h0;
    @(posedge clk); #1;
    if (in_ready !== 1'b1) $display("FAIL rel_in_ready got %b want 1", in_ready); else passed++;
    checks++;
  endtask

  task automatic test_ops();
    exp_t e;
    logic [7:0] r;
    logic [3:0] f;
    int lat;
    logic [3:0] o;
    logic [7:0] a, b;
    for (int i = 0; i < 51; i++) begin
      if (i < 21) begin
        o = tbl[i][19:16]; a = tbl[i][15:8]; b = tbl[i][7:0];
      end else begin
        o = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom);
      end
      send(o, a, b);
      collect(r, f, lat);
      e = pop_exp();
      if (r !== e.res) $display("FAIL op_result i=%0d op=%0d got %h want %h", i, o, r, e.res);
      else passed++;
      checks++;
      if (f !== e.fl) $display("FAIL op_flags i=%0d op=%0d got %b want %b", i, o, f, e.fl);
      else passed++;
      checks++;
      if (lat !== e.lat) $display("FAIL op_latency i=%0d op=%0d got %0d want %0d", i, o, lat, e.lat);
      else passed++;
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    exp_t e;
    logic [7:0] r;
    logic [3:0] f;
    int lat;
    out_ready = 1'b0;
    send(4'd2, 8'h7F, 8'h01);
    collect(r, f, lat);
    e = pop_exp();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1) $display("FAIL hold_valid k=%0d got %b want 1", k, out_valid);
      else passed++;
      checks++;
      if (result !== e.res) $display("FAIL hold_result k=%0d got %h want %h", k, result, e.res);
      else passed++;
      checks++;
      if (flags !== e.fl) $display("FAIL hold_flags k=%0d got %b want %b", k, flags, e.fl);
      else passed++;
      checks++;
      if (in_ready !== 1'b0) $display("FAIL hold_in_ready k=%0d got %b want 0", k, in_ready);
      else passed++;
      checks++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL hold_release out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else passed++;
    checks++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] r;
    logic [3:0] f;
    int lat;
    out_ready = 1'b0;
    send(4'd6, 8'hAA, 8'h0F);
    collect(r, f, lat);
    e = pop_exp();
    if (r !== e.res) $display("FAIL b2b_first got %h want %h", r, e.res); else passed++;
    checks++;
    in_valid = 1'b1; op = 4'd2; p1 = 8'h10; p2 = 8'h20;
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_no_overlap out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else passed++;
    checks++;
    e = model(4'd2, 8'h10, 8'h20, mflags);
    mflags = e.fl;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = pop_exp();
    if (out_valid !== 1'b1 || result !== e.res)
      $display("FAIL b2b_second out_valid=%b result=%h want 1 %h", out_valid, result, e.res);
    else passed++;
    checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    exp_t e;
    logic [7:0] r;
    logic [3:0] f;
    int lat, seen;
    send(4'd8, 8'hA5, 8'h07);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    if (result !== 8'h00) $display("FAIL mid_rst_result got %h want 00", result); else passed++;
    checks++;
    if (flags !== 4'h0) $display("FAIL mid_rst_flags got %b want 0000", flags); else passed++;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL mid_rst_ctrl out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    else passed++;
    checks++;
    sb.delete();
    mflags = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    if (seen !== 0) $display("FAIL mid_rst_abandon out_valid cycles=%0d want 0", seen); else passed++;
    checks++;
    send(4'd2, 8'h01, 8'h01);
    collect(r, f, lat);
    e = pop_exp();
    if (r !== e.res) $display("FAIL post_rst_result got %h want %h", r, e.res); else passed++;
    checks++;
    if (f !== e.fl) $display("FAIL post_rst_flags got %b want %b", f, e.fl); else passed++;
    checks++;
    if (lat !== e.lat) $display("FAIL post_rst_latency got %0d want %0d", lat, e.lat); else passed++;
    checks++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_hold();
    test_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
